// File: rtl/irda_tx_arbiter.sv
// Arbiter sharing one half-duplex IrDA byte transmitter between two show-ahead byte FIFOs.
// Optional post-receive guard timer enabled by defining GUARD_TIMER_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for an eligible request; winner latched on exit
// ISSUE     | one-cycle pop of the granted FIFO and send strobe
// WAIT_ACK  | waiting for the transmitter to drop tx_available (bounded)
// WAIT_DONE | transmitter busy with the byte; waits for tx_available
module irda_tx_arbiter #(
    parameter int DW           = 8,
    parameter int MAX_BURST    = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_empty0,
    input  logic [DW-1:0] i_head0,
    output logic          o_rd0,
    input  logic          i_empty1,
    input  logic [DW-1:0] i_head1,
    output logic          o_rd1,
    input  logic          i_rx_busy,
    input  logic          i_tx_available,
    output logic          o_send,
    output logic [DW-1:0] o_tx_data,
    output logic          o_grant_id,
    output logic          o_busy,
    output logic          o_ack_err
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_ISSUE     = 4'b0010,
        S_WAIT_ACK  = 4'b0100,
        S_WAIT_DONE = 4'b1000
    } state_t;

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_tx_data;
    logic            r_grant;
    logic [BW-1:0]   r_burst;
    logic [TW-1:0]   r_timer;
    logic            w_guard_clear;
    logic            w_eligible;
    logic            w_winner;
    logic            w_grant;
    logic [BW-1:0]   w_burst_nxt;

`ifdef GUARD_TIMER_EN
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    logic [GW-1:0] r_guard;

    always_ff @(posedge clock) begin
        if (reset)
            r_guard <= '0;
        else if (i_rx_busy)
            r_guard <= GW'(GUARD_CYCLES);
        else if (r_guard != '0)
            r_guard <= r_guard - 1'b1;
    end

    assign w_guard_clear = (r_guard == '0);
`else
    // Without the timer the guard is never armed.
    assign w_guard_clear = (GUARD_CYCLES >= 0);
`endif

    assign w_eligible = !i_rx_busy && w_guard_clear && i_tx_available &&
                        (!i_empty0 || !i_empty1);

    // Stay with the last source until its burst allowance is used up.
    always_comb begin
        w_winner = i_empty0;
        if (!i_empty0 && !i_empty1)
            w_winner = (r_burst < BURST_MAX) ? r_grant : !r_grant;
    end

    assign w_burst_nxt = (w_winner != r_grant)   ? BW'(1) :
                         (r_burst < BURST_MAX)   ? r_burst + 1'b1 : r_burst;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
            r_grant   <= 1'b1;
            r_burst   <= BURST_MAX;
            r_timer   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_tx_data <= w_winner ? i_head1 : i_head0;
                r_grant   <= w_winner;
                r_burst   <= w_burst_nxt;
            end
            if (r_state == S_ISSUE)
                r_timer <= TIMER_LOAD;
            else if (r_state == S_WAIT_ACK && r_timer != '0)
                r_timer <= r_timer - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        o_rd0       = 1'b0;
        o_rd1       = 1'b0;
        o_send      = 1'b0;
        o_ack_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_eligible) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_send      = 1'b1;
                o_rd0       = !r_grant;
                o_rd1       = r_grant;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!i_tx_available) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_timer == '0) begin
                    o_ack_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_available)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_irda_tx_arbiter.sv
// Directed self-checking bench for irda_tx_arbiter: grant latency, burst fairness,
// receive lockout, ack timeout and mid-operation reset.
module tb_irda_tx_arbiter;

`ifdef GUARD_TIMER_EN
    localparam int RX_LAT = 17;
`else
    localparam int RX_LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       i_empty0, i_empty1;
    logic [7:0] i_head0, i_head1;
    logic       o_rd0, o_rd1;
    logic       i_rx_busy, i_tx_available;
    logic       o_send;
    logic [7:0] o_tx_data;
    logic       o_grant_id, o_busy, o_ack_err;

    int vec  = 0;
    int errs = 0;

    always #5 clock = ~clock;

    irda_tx_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .i_empty0       (i_empty0),
        .i_head0        (i_head0),
        .o_rd0          (o_rd0),
        .i_empty1       (i_empty1),
        .i_head1        (i_head1),
        .o_rd1          (o_rd1),
        .i_rx_busy      (i_rx_busy),
        .i_tx_available (i_tx_available),
        .o_send         (o_send),
        .o_tx_data      (o_tx_data),
        .o_grant_id     (o_grant_id),
        .o_busy         (o_busy),
        .o_ack_err      (o_ack_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd0"},     32'(o_rd0), 0);
        chk({tag, "_rd1"},     32'(o_rd1), 0);
        chk({tag, "_send"},    32'(o_send), 0);
        chk({tag, "_ack_err"}, 32'(o_ack_err), 0);
        chk({tag, "_busy"},    32'(o_busy), 0);
        chk({tag, "_tx_data"}, 32'(o_tx_data), 0);
        chk({tag, "_grant"},   32'(o_grant_id), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_empty0 = 1'b1; i_head0 = 8'h00;
        i_empty1 = 1'b1; i_head1 = 8'h00;
        i_rx_busy = 1'b0; i_tx_available = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_send(input int limit, output int lat);
        lat = 0;
        while (lat < limit) begin
            @(negedge clock);
            lat++;
            if (o_send) break;
        end
    endtask

    // Called on the ISSUE cycle: transmitter takes the byte, runs briefly, then frees up.
    task automatic finish_byte(input string tag);
        i_tx_available = 1'b0;
        @(negedge clock);
        @(negedge clock);
        i_tx_available = 1'b1;
        @(negedge clock);
        chk({tag, "_idle_after"}, 32'(o_busy), 0);
    endtask

    initial begin
        int lat, k, extra;
        int cnt0, cnt1, p0, p1, nsend, nrd, tx_left, exp_src;
        int order[10];
        order = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        // reset values
        do_reset();
        chk_reset_vals("rst");

        // T1: single byte from req0
        i_empty0 = 1'b0; i_head0 = 8'hA5;
        @(negedge clock);
        chk("t1_send",  32'(o_send), 1);
        chk("t1_rd",    32'({o_rd1, o_rd0}), 32'h1);
        chk("t1_data",  32'(o_tx_data), 32'hA5);
        chk("t1_grant", 32'(o_grant_id), 0);
        chk("t1_busy",  32'(o_busy), 1);
        i_empty0 = 1'b1;
        i_tx_available = 1'b0;
        @(negedge clock);
        chk("t1_send_once", 32'(o_send), 0);
        @(negedge clock);
        chk("t1_wait_done_busy", 32'(o_busy), 1);
        i_tx_available = 1'b1;
        @(negedge clock);
        chk("t1_idle", 32'(o_busy), 0);
        chk("t1_data_held", 32'(o_tx_data), 32'hA5);

        // T2: burst fairness with two loaded FIFOs
        do_reset();
        cnt0 = 10; cnt1 = 10; p0 = 0; p1 = 0; nsend = 0; nrd = 0; tx_left = 0;
        i_empty0 = 1'b0; i_head0 = 8'h10;
        i_empty1 = 1'b0; i_head1 = 8'h80;
        for (int cyc = 0; cyc < 400 && !(nsend == 10 && !o_busy); cyc++) begin
            @(negedge clock);
            if (o_rd0) nrd++;
            if (o_rd1) nrd++;
            if (o_send && nsend < 10) begin
                exp_src = order[nsend];
                chk("t2_grant", 32'(o_grant_id), 32'(exp_src));
                chk("t2_data",  32'(o_tx_data),
                    (exp_src == 1) ? 32'(8'h80 + p1) : 32'(8'h10 + p0));
                chk("t2_rd",    32'({o_rd1, o_rd0}), (exp_src == 1) ? 32'h2 : 32'h1);
                nsend++;
                tx_left = 3;
            end
            if (o_rd0) begin p0++; cnt0--; end
            if (o_rd1) begin p1++; cnt1--; end
            if (nsend == 10) begin cnt0 = 0; cnt1 = 0; end
            i_tx_available = (tx_left == 0);
            if (tx_left > 0) tx_left--;
            i_empty0 = (cnt0 <= 0); i_head0 = 8'(8'h10 + p0);
            i_empty1 = (cnt1 <= 0); i_head1 = 8'(8'h80 + p1);
        end
        chk("t2_sends", 32'(nsend), 10);
        chk("t2_rd_count", 32'(nrd), 10);
        chk("t2_idle", 32'(o_busy), 0);

        // T3: receive lockout, simultaneous with data arrival
        i_empty0 = 1'b0; i_head0 = 8'h3C; i_rx_busy = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            chk("t3_blocked", 32'({o_send, o_busy}), 0);
        end
        i_rx_busy = 1'b0;
        wait_send(40, lat);
        chk("t3_latency", 32'(lat), 32'(RX_LAT));
        chk("t3_data", 32'(o_tx_data), 32'h3C);
        chk("t3_rd",   32'({o_rd1, o_rd0}), 32'h1);
        i_empty0 = 1'b1;
        finish_byte("t3");

        // T4: rx_busy rises while the byte is in flight
        i_empty0 = 1'b0; i_head0 = 8'h5A;
        wait_send(10, lat);
        chk("t4_latency", 32'(lat), 1);
        chk("t4_data", 32'(o_tx_data), 32'h5A);
        i_head0 = 8'h5B;
        i_tx_available = 1'b0;
        @(negedge clock);
        @(negedge clock);
        i_rx_busy = 1'b1;
        chk("t4_in_flight", 32'(o_busy), 1);
        @(negedge clock);
        chk("t4_still_busy", 32'(o_busy), 1);
        i_tx_available = 1'b1;
        @(negedge clock);
        chk("t4_byte_done", 32'(o_busy), 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            chk("t4_blocked", 32'(o_send), 0);
        end
        i_rx_busy = 1'b0;
        wait_send(40, lat);
        chk("t4_latency2", 32'(lat), 32'(RX_LAT));
        chk("t4_data2", 32'(o_tx_data), 32'h5B);
        i_empty0 = 1'b1;
        finish_byte("t4");

        // T5: transmitter never acknowledges
        i_empty0 = 1'b0; i_head0 = 8'h66;
        wait_send(10, lat);
        chk("t5_latency", 32'(lat), 1);
        chk("t5_data", 32'(o_tx_data), 32'h66);
        i_head0 = 8'h67;
        k = 0; extra = 0;
        while (k < 100) begin
            @(negedge clock);
            k++;
            if (o_send) extra++;
            if (o_ack_err) break;
        end
        chk("t5_ack_cycles", 32'(k), 64);
        chk("t5_busy_at_err", 32'(o_busy), 1);
        chk("t5_no_resend", 32'(extra), 0);
        @(negedge clock);
        chk("t5_ack_pulse", 32'({o_ack_err, o_busy}), 0);
        @(negedge clock);
        chk("t5_next_send", 32'(o_send), 1);
        chk("t5_next_data", 32'(o_tx_data), 32'h67);
        i_empty0 = 1'b1;
        finish_byte("t5");

        // T6: reset while waiting for ack
        i_empty0 = 1'b0; i_head0 = 8'h77;
        wait_send(10, lat);
        chk("t6_data", 32'(o_tx_data), 32'h77);
        i_empty0 = 1'b1;
        @(negedge clock);
        chk("t6_wait_ack", 32'(o_busy), 1);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("t6");
        reset = 1'b0;
        @(negedge clock);
        chk("t6_stays_idle", 32'({o_send, o_busy}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
